l2_cache_arb: RTL and testbench

// First stage of the L2 pipeline, directly upstream of the tag stage. Each cycle it picks at most one

---
 rtl/l2_cache_arb_if.sv | 64 ++++++
 rtl/l2_cache_arb.sv | 120 ++++++++++++
 tb/tb_l2_cache_arb.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_arb_if.sv
// rtl/l2_cache_arb_if.sv - packet types and request/grant bus for the L2 arbitration stage
//
// l2_cache_arb_pkg : line width, request opcodes and the l2req_packet_t layout.
// l2_cache_arb_if  : bus between the requesters and the arbiter.
//   core_l2req_valid/packet/ready  per-core request handshake, core i at packet slice i
//   fill_valid/l2req_packet/data/ready  restarted fill from the memory interface
//   stall_pipeline                 downstream cannot accept this cycle
//   arb_l2req_packet/is_l2_fill/data_from_memory  registered winner towards the tag stage
//   modport master : requester side (drives valids, packets, stall)
//   modport slave  : arbiter side (drives readies and arb_* outputs)

package l2_cache_arb_pkg;
    localparam int CACHE_LINE_BITS = 512;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_DINVALIDATE = 3'd3,
        L2REQ_LOAD_SYNC   = 3'd4,
        L2REQ_STORE_SYNC  = 3'd5
    } l2req_op_t;

    typedef struct packed {
        logic        valid;
        l2req_op_t   op;
        logic [3:0]  id;
        logic [31:0] address;
    } l2req_packet_t;
endpackage

interface l2_cache_arb_if #(
    parameter int NUM_REQ = 4
);
    import l2_cache_arb_pkg::*;

    localparam int PKT_W = $bits(l2req_packet_t);

    logic [NUM_REQ-1:0]         core_l2req_valid;
    logic [NUM_REQ*PKT_W-1:0]   core_l2req_packet;
    logic [NUM_REQ-1:0]         core_l2req_ready;
    logic                       fill_valid;
    l2req_packet_t              fill_l2req_packet;
    logic [CACHE_LINE_BITS-1:0] fill_data;
    logic                       fill_ready;
    logic                       stall_pipeline;
    l2req_packet_t              arb_l2req_packet;
    logic                       arb_is_l2_fill;
    logic [CACHE_LINE_BITS-1:0] arb_data_from_memory;

    modport master (
        output core_l2req_valid, core_l2req_packet, fill_valid, fill_l2req_packet,
               fill_data, stall_pipeline,
        input  core_l2req_ready, fill_ready, arb_l2req_packet, arb_is_l2_fill,
               arb_data_from_memory
    );

    modport slave (
        input  core_l2req_valid, core_l2req_packet, fill_valid, fill_l2req_packet,
               fill_data, stall_pipeline,
        output core_l2req_ready, fill_ready, arb_l2req_packet, arb_is_l2_fill,
               arb_data_from_memory
    );
endinterface

// File: rtl/l2_cache_arb.sv
// rtl/l2_cache_arb.sv - L2 pipeline arbitration stage: fill-priority with bounded streak, round-robin cores
//
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    l2_cache_arb_if.slave: core/fill request handshakes in, combinational readies out,
//          registered winner (arb_l2req_packet, arb_is_l2_fill, arb_data_from_memory) out.
// Parameters:
//   NUM_REQ          number of core request ports (>= 1, any value); must match the interface
//   FILL_STREAK_MAX  consecutive fill grants allowed while a core request is waiting

module l2_cache_arb
    import l2_cache_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int FILL_STREAK_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    l2_cache_arb_if.slave bus
);

    localparam int PKT_W    = $bits(l2req_packet_t);
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STREAK_W = $clog2(FILL_STREAK_MAX + 1);

    logic [PTR_W-1:0]    rr_ptr;
    logic [STREAK_W-1:0] fill_streak;

    logic                any_core;
    logic                core_found;
    logic [PTR_W-1:0]    core_sel;
    logic [PTR_W-1:0]    rr_next;
    logic                fill_grant;
    logic                core_grant;
    logic [STREAK_W-1:0] streak_inc;
    l2req_packet_t       core_pkt;
    l2req_packet_t       fill_pkt;

    assign any_core = |bus.core_l2req_valid;

    // Round-robin scan starting at rr_ptr; the index is folded back by one subtraction so that
    // non-power-of-two port counts wrap correctly.
    always_comb begin
        int idx;
        idx        = 0;
        core_found = 1'b0;
        core_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!core_found && bus.core_l2req_valid[idx]) begin
                core_found = 1'b1;
                core_sel   = PTR_W'(idx);
            end
        end
    end

    assign rr_next = (core_sel == PTR_W'(NUM_REQ - 1)) ? '0 : core_sel + PTR_W'(1);

    // The streak only limits fills while a core is waiting; once it reaches the limit the
    // fill loses exactly one cycle to a core, which clears the streak.
    assign fill_grant = reset && !bus.stall_pipeline && bus.fill_valid &&
                        (!any_core || (fill_streak < STREAK_W'(FILL_STREAK_MAX)));
    assign core_grant = reset && !bus.stall_pipeline && !fill_grant && core_found;

    assign streak_inc = (fill_streak == STREAK_W'(FILL_STREAK_MAX)) ? fill_streak
                                                                     : fill_streak + STREAK_W'(1);

    always_comb begin
        bus.core_l2req_ready = '0;
        if (core_grant) begin
            bus.core_l2req_ready[core_sel] = 1'b1;
        end
    end

    assign bus.fill_ready = fill_grant;

    always_comb begin
        core_pkt       = bus.core_l2req_packet[int'(core_sel) * PKT_W +: PKT_W];
        core_pkt.valid = 1'b1;
        fill_pkt       = bus.fill_l2req_packet;
        fill_pkt.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.arb_l2req_packet     <= '0;
            bus.arb_is_l2_fill       <= 1'b0;
            bus.arb_data_from_memory <= '0;
            rr_ptr                   <= '0;
            fill_streak              <= '0;
        end else if (fill_grant) begin
            bus.arb_l2req_packet     <= fill_pkt;
            bus.arb_is_l2_fill       <= 1'b1;
            bus.arb_data_from_memory <= bus.fill_data;
            fill_streak              <= any_core ? streak_inc : '0;
        end else if (core_grant) begin
            bus.arb_l2req_packet <= core_pkt;
            bus.arb_is_l2_fill   <= 1'b0;
            rr_ptr               <= rr_next;
            fill_streak          <= '0;
        end else begin
            // Bubble; line data is left alone since it is only meaningful alongside a fill.
            bus.arb_l2req_packet <= '0;
            bus.arb_is_l2_fill   <= 1'b0;
            if (!bus.stall_pipeline) begin
                fill_streak <= '0;
            end
        end
    end

    // Flush/invalidate never go to memory, so one coming back as a fill means a broken upstream.
    fill_op_legal: assert property (@(posedge clk) disable iff (!reset)
        fill_grant |-> (bus.fill_l2req_packet.op != L2REQ_FLUSH &&
                        bus.fill_l2req_packet.op != L2REQ_DINVALIDATE));

endmodule

// File: tb/tb_l2_cache_arb.sv
// tb/tb_l2_cache_arb.sv - directed self-checking bench for l2_cache_arb

module tb_l2_cache_arb;
    import l2_cache_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    l2req_packet_t              pkts [4];
    l2req_packet_t              fill_pkt;
    logic [CACHE_LINE_BITS-1:0] line_a5;
    logic [CACHE_LINE_BITS-1:0] line_3c;

    always #5 clk = ~clk;

    l2_cache_arb_if #(.NUM_REQ(4)) bus ();

    l2_cache_arb #(.NUM_REQ(4), .FILL_STREAK_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic l2req_packet_t with_valid(input l2req_packet_t p);
        l2req_packet_t r;
        r       = p;
        r.valid = 1'b1;
        return r;
    endfunction

    // Leaves the bench at a falling edge with reset released and all requests idle.
    task automatic apply_reset();
        @(negedge clk);
        reset                  = 1'b0;
        bus.core_l2req_valid   = '0;
        bus.fill_valid         = 1'b0;
        bus.stall_pipeline     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset                = 1'b0;
        bus.core_l2req_valid = 4'hF;
        bus.fill_valid       = 1'b1;
        bus.stall_pipeline   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.core_l2req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_core_ready[%0d]: got %b expected 0000", c, bus.core_l2req_ready);
            end
            checks++;
            if (bus.fill_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_fill_ready[%0d]: got %b expected 0", c, bus.fill_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_l2req_packet !== l2req_packet_t'(0)) begin
                errors++;
                $display("FAIL reset_arb_packet[%0d]: got %h expected 0", c, bus.arb_l2req_packet);
            end
            checks++;
            if (bus.arb_is_l2_fill !== 1'b0) begin
                errors++;
                $display("FAIL reset_arb_is_fill[%0d]: got %b expected 0", c, bus.arb_is_l2_fill);
            end
            checks++;
            if (bus.arb_data_from_memory !== '0) begin
                errors++;
                $display("FAIL reset_arb_data[%0d]: got %h expected 0", c, bus.arb_data_from_memory);
            end
            @(negedge clk);
        end
        reset                = 1'b1;
        bus.core_l2req_valid = '0;
        bus.fill_valid       = 1'b0;
    endtask

    task automatic test_round_robin();
        int e;
        apply_reset();
        bus.core_l2req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            e = i % 4;
            #1;
            checks++;
            if (bus.core_l2req_ready !== 4'(1 << e) || bus.fill_ready !== 1'b0) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got core=%b fill=%b expected core=%b fill=0",
                         i, bus.core_l2req_ready, bus.fill_ready, 4'(1 << e));
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_l2req_packet !== with_valid(pkts[e]) || bus.arb_is_l2_fill !== 1'b0) begin
                errors++;
                $display("FAIL rr_output[%0d]: got pkt=%h fill=%b expected pkt=%h fill=0",
                         i, bus.arb_l2req_packet, bus.arb_is_l2_fill, with_valid(pkts[e]));
            end
            @(negedge clk);
        end
        bus.core_l2req_valid = '0;
    endtask

    task automatic test_fill_streak();
        logic exp_fill [6];
        exp_fill = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        bus.fill_data        = line_3c;
        bus.core_l2req_valid = 4'b0100;
        bus.fill_valid       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (exp_fill[i] ? (bus.fill_ready !== 1'b1 || bus.core_l2req_ready !== 4'b0000)
                            : (bus.fill_ready !== 1'b0 || bus.core_l2req_ready !== 4'b0100)) begin
                errors++;
                $display("FAIL streak_ready[%0d]: got core=%b fill=%b expected fill_grant=%b",
                         i, bus.core_l2req_ready, bus.fill_ready, exp_fill[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_is_l2_fill !== exp_fill[i] ||
                bus.arb_l2req_packet !== (exp_fill[i] ? with_valid(fill_pkt) : with_valid(pkts[2]))) begin
                errors++;
                $display("FAIL streak_output[%0d]: got pkt=%h fill=%b expected fill=%b",
                         i, bus.arb_l2req_packet, bus.arb_is_l2_fill, exp_fill[i]);
            end
            if (exp_fill[i]) begin
                checks++;
                if (bus.arb_data_from_memory !== line_3c) begin
                    errors++;
                    $display("FAIL streak_data[%0d]: got %h expected %h",
                             i, bus.arb_data_from_memory, line_3c);
                end
            end
            @(negedge clk);
        end
        bus.core_l2req_valid = '0;
        bus.fill_valid       = 1'b0;
    endtask

    task automatic test_fill_only();
        apply_reset();
        bus.fill_data  = line_a5;
        bus.fill_valid = 1'b1;
        // Six uncontested fills must not advance the streak; a core arriving afterwards
        // still loses to the fill.
        for (int i = 0; i < 7; i++) begin
            if (i == 6) bus.core_l2req_valid = 4'b0001;
            #1;
            checks++;
            if (bus.fill_ready !== 1'b1 || bus.core_l2req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL fill_only_ready[%0d]: got core=%b fill=%b expected core=0000 fill=1",
                         i, bus.core_l2req_ready, bus.fill_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_is_l2_fill !== 1'b1 || bus.arb_data_from_memory !== line_a5 ||
                bus.arb_l2req_packet !== with_valid(fill_pkt)) begin
                errors++;
                $display("FAIL fill_only_output[%0d]: got fill=%b pkt=%h data=%h",
                         i, bus.arb_is_l2_fill, bus.arb_l2req_packet, bus.arb_data_from_memory);
            end
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        #1;
        checks++;
        if (bus.core_l2req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL fill_then_core_ready: got %b expected 0001", bus.core_l2req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.arb_is_l2_fill !== 1'b0 || bus.arb_l2req_packet !== with_valid(pkts[0]) ||
            bus.arb_data_from_memory !== line_a5) begin
            errors++;
            $display("FAIL data_hold: got fill=%b pkt=%h data=%h expected fill=0 data=%h",
                     bus.arb_is_l2_fill, bus.arb_l2req_packet, bus.arb_data_from_memory, line_a5);
        end
        @(negedge clk);
        bus.core_l2req_valid = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        bus.core_l2req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.core_l2req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL stall_setup_ready: got %b expected 0001", bus.core_l2req_ready);
        end
        @(negedge clk);
        bus.core_l2req_valid = 4'b0011;
        bus.fill_valid       = 1'b1;
        bus.stall_pipeline   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.core_l2req_ready !== 4'b0000 || bus.fill_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got core=%b fill=%b expected all 0",
                         i, bus.core_l2req_ready, bus.fill_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_l2req_packet !== l2req_packet_t'(0) || bus.arb_is_l2_fill !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble[%0d]: got pkt=%h fill=%b expected 0",
                         i, bus.arb_l2req_packet, bus.arb_is_l2_fill);
            end
            @(negedge clk);
        end
        bus.stall_pipeline = 1'b0;
        bus.fill_valid     = 1'b0;
        #1;
        checks++;
        if (bus.core_l2req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 0010", bus.core_l2req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.arb_l2req_packet !== with_valid(pkts[1])) begin
            errors++;
            $display("FAIL stall_release_output: got %h expected %h",
                     bus.arb_l2req_packet, with_valid(pkts[1]));
        end
        @(negedge clk);
        bus.core_l2req_valid = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] vin  [3];
        logic [3:0] rdy  [3];
        int         win  [3];
        vin = '{4'b0100, 4'b1000, 4'b1001};
        rdy = '{4'b0100, 4'b1000, 4'b0001};
        win = '{2, 3, 0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            bus.core_l2req_valid = vin[i];
            #1;
            checks++;
            if (bus.core_l2req_ready !== rdy[i]) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: got %b expected %b", i, bus.core_l2req_ready, rdy[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.arb_l2req_packet !== with_valid(pkts[win[i]]) || bus.arb_is_l2_fill !== 1'b0) begin
                errors++;
                $display("FAIL wrap_output[%0d]: got pkt=%h expected %h",
                         i, bus.arb_l2req_packet, with_valid(pkts[win[i]]));
            end
            @(negedge clk);
        end
        bus.core_l2req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pkts[i].valid   = 1'b0;
            pkts[i].op      = (i % 2 == 0) ? L2REQ_LOAD : L2REQ_STORE;
            pkts[i].id      = 4'(i + 1);
            pkts[i].address = 32'h1000_0000 + 32'(i * 64);
        end
        fill_pkt.valid   = 1'b0;
        fill_pkt.op      = L2REQ_LOAD;
        fill_pkt.id      = 4'hF;
        fill_pkt.address = 32'hDEAD_BEC0;
        line_a5          = {64{8'hA5}};
        line_3c          = {64{8'h3C}};

        bus.core_l2req_packet = {pkts[3], pkts[2], pkts[1], pkts[0]};
        bus.fill_l2req_packet = fill_pkt;
        bus.fill_data         = '0;

        test_reset();
        test_round_robin();
        test_fill_streak();
        test_fill_only();
        test_stall();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
